// File: rtl/multicycle_control_if.sv
// ============================================================================
// multicycle_control_if : control bus between the control FSM and the datapath
// Rev 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PC_write;
  logic       address_src;
  logic       IR_write;
  logic       reg_write;
  logic       mem_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_A;
  logic [1:0] alu_src_B;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal;

  // control FSM side
  modport master (
    input  op, funct3, funct7b5, zero,
    output PC_write, address_src, IR_write, reg_write, mem_write,
           result_src, alu_src_A, alu_src_B, imm_src, alu_control, illegal
  );

  // datapath side
  modport slave (
    output op, funct3, funct7b5, zero,
    input  PC_write, address_src, IR_write, reg_write, mem_write,
           result_src, alu_src_A, alu_src_B, imm_src, alu_control, illegal
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : control FSM of the 32-bit multicycle RISC-V core
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus,
  output logic [CNT_W-1:0]      instret
);

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_beq    = 7'b1100011;
  localparam logic [2:0] c_alu_add   = 3'b000;
  localparam logic [2:0] c_alu_sub   = 3'b001;
  localparam logic [2:0] c_alu_and   = 3'b010;
  localparam logic [2:0] c_alu_or    = 3'b011;
  localparam logic [2:0] c_alu_slt   = 3'b101;
  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic             w_unsupported;
  logic [2:0]       w_funct_alu;
  logic             w_pc_write, w_address_src, w_ir_write, w_reg_write, w_mem_write;
  logic [1:0]       w_result_src, w_alu_src_a, w_alu_src_b;
  logic [2:0]       w_alu_control;

  assign w_unsupported = !(bus.op == c_op_load  || bus.op == c_op_store ||
                           bus.op == c_op_rtype || bus.op == c_op_itype ||
                           bus.op == c_op_jal   || bus.op == c_op_beq);

  // Only the states that finish an instruction and return to FETCH retire it.
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                    (r_state == S_ALUWB) || (r_state == S_BEQ);

  always_comb begin
    w_funct_alu = c_alu_add;
    case (bus.funct3)
      3'b000:  w_funct_alu = (bus.op[5] & bus.funct7b5) ? c_alu_sub : c_alu_add;
      3'b010:  w_funct_alu = c_alu_slt;
      3'b110:  w_funct_alu = c_alu_or;
      3'b111:  w_funct_alu = c_alu_and;
      default: w_funct_alu = c_alu_add;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (bus.op == c_op_load || bus.op == c_op_store) w_next = S_MEMADR;
        else if (bus.op == c_op_rtype)                   w_next = S_EXECR;
        else if (bus.op == c_op_itype)                   w_next = S_EXECI;
        else if (bus.op == c_op_jal)                     w_next = S_JAL;
        else if (bus.op == c_op_beq)                     w_next = S_BEQ;
        else                                             w_next = S_FETCH;
      end
      S_MEMADR: w_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECR:   w_next = S_ALUWB;
      S_EXECI:   w_next = S_ALUWB;
      S_JAL:     w_next = S_ALUWB;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_write    = 1'b0;
    w_address_src = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_write   = 1'b0;
    w_result_src  = 2'd0;
    w_alu_src_a   = 2'd0;
    w_alu_src_b   = 2'd0;
    w_alu_control = c_alu_add;
    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_pc_write   = 1'b1;
        w_alu_src_b  = 2'd2;
        w_result_src = 2'd2;
      end
      S_DECODE: begin
        w_alu_src_a = 2'd1;
        w_alu_src_b = 2'd1;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'd2;
        w_alu_src_b = 2'd1;
      end
      S_MEMREAD: w_address_src = 1'b1;
      S_MEMWB: begin
        w_result_src = 2'd1;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_address_src = 1'b1;
        w_mem_write   = 1'b1;
      end
      S_EXECR: begin
        w_alu_src_a   = 2'd2;
        w_alu_control = w_funct_alu;
      end
      S_EXECI: begin
        w_alu_src_a   = 2'd2;
        w_alu_src_b   = 2'd1;
        w_alu_control = w_funct_alu;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_JAL: begin
        w_alu_src_a = 2'd1;
        w_alu_src_b = 2'd2;
        w_pc_write  = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a   = 2'd2;
        w_alu_control = c_alu_sub;
        w_pc_write    = bus.zero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + c_one;
    end
  end

  // Write enables are held off for as long as reset is asserted.
  assign bus.PC_write    = rst & w_pc_write;
  assign bus.IR_write    = rst & w_ir_write;
  assign bus.reg_write   = rst & w_reg_write;
  assign bus.mem_write   = rst & w_mem_write;
  assign bus.illegal     = rst & (r_state == S_DECODE) & w_unsupported;
  assign bus.address_src = w_address_src;
  assign bus.result_src  = w_result_src;
  assign bus.alu_src_A   = w_alu_src_a;
  assign bus.alu_src_B   = w_alu_src_b;
  assign bus.alu_control = w_alu_control;
  assign bus.imm_src     = (bus.op == c_op_store) ? 2'd1 :
                           (bus.op == c_op_beq)   ? 2'd2 :
                           (bus.op == c_op_jal)   ? 2'd3 : 2'd0;
  assign instret         = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control : directed scoreboard bench for multicycle_control
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [31:0] instret;
  int          tests;
  int          fails;
  logic [31:0] exp_instret;

  multicycle_control_if bus ();

  multicycle_control #(.CNT_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .instret (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {bus.PC_write, bus.address_src, bus.IR_write, bus.reg_write, bus.mem_write,
                bus.result_src, bus.alu_src_A, bus.alu_src_B, bus.imm_src,
                bus.alu_control, bus.illegal};

  typedef struct {
    logic [16:0] ctrl;
    logic [31:0] icnt;
    string       tag;
  } exp_t;

  exp_t sb[$];

  function automatic logic [16:0] mk(input logic pc, input logic as_, input logic ir,
                                     input logic rw, input logic mw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] im, input logic [2:0] alu,
                                     input logic ill);
    return {pc, as_, ir, rw, mw, rs, a, b, im, alu, ill};
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] op);
    if (op == 7'b0100011) return 2'd1;
    if (op == 7'b1100011) return 2'd2;
    if (op == 7'b1101111) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input logic [16:0] c, input string tag);
    exp_t e;
    e.ctrl = c;
    e.icnt = exp_instret;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Drive one instruction's inputs and queue the expected per-cycle outputs.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input string tag);
    logic [1:0] im;
    logic [2:0] alu;
    logic       legal;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    im    = exp_imm(op);
    alu   = exp_alu(op, f3, f7);
    legal = 1'b1;
    push(mk(1,0,1,0,0,2'd2,2'd0,2'd2,im,3'b000,0), {tag, "_fetch"});
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011:
        push(mk(0,0,0,0,0,2'd0,2'd1,2'd1,im,3'b000,0), {tag, "_decode"});
      default: begin
        push(mk(0,0,0,0,0,2'd0,2'd1,2'd1,im,3'b000,1), {tag, "_decode"});
        legal = 1'b0;
      end
    endcase
    case (op)
      7'b0000011: begin
        push(mk(0,0,0,0,0,2'd0,2'd2,2'd1,im,3'b000,0), {tag, "_memadr"});
        push(mk(0,1,0,0,0,2'd0,2'd0,2'd0,im,3'b000,0), {tag, "_memread"});
        push(mk(0,0,0,1,0,2'd1,2'd0,2'd0,im,3'b000,0), {tag, "_memwb"});
      end
      7'b0100011: begin
        push(mk(0,0,0,0,0,2'd0,2'd2,2'd1,im,3'b000,0), {tag, "_memadr"});
        push(mk(0,1,0,0,1,2'd0,2'd0,2'd0,im,3'b000,0), {tag, "_memwrite"});
      end
      7'b0110011: begin
        push(mk(0,0,0,0,0,2'd0,2'd2,2'd0,im,alu,0), {tag, "_execr"});
        push(mk(0,0,0,1,0,2'd0,2'd0,2'd0,im,3'b000,0), {tag, "_aluwb"});
      end
      7'b0010011: begin
        push(mk(0,0,0,0,0,2'd0,2'd2,2'd1,im,alu,0), {tag, "_execi"});
        push(mk(0,0,0,1,0,2'd0,2'd0,2'd0,im,3'b000,0), {tag, "_aluwb"});
      end
      7'b1101111: begin
        push(mk(1,0,0,0,0,2'd0,2'd1,2'd2,im,3'b000,0), {tag, "_jal"});
        push(mk(0,0,0,1,0,2'd0,2'd0,2'd0,im,3'b000,0), {tag, "_aluwb"});
      end
      7'b1100011:
        push(mk(z,0,0,0,0,2'd0,2'd2,2'd0,im,3'b001,0), {tag, "_beq"});
      default: ;
    endcase
    if (legal) exp_instret = exp_instret + 32'd1;
  endtask

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (obs === e.ctrl) else begin
      fails++;
      $error("FAIL %s ctrl observed=%h expected=%h", e.tag, obs, e.ctrl);
    end
    tests++;
    assert (instret === e.icnt) else begin
      fails++;
      $error("FAIL %s instret observed=%0d expected=%0d", e.tag, instret, e.icnt);
    end
  endtask

  // One check per cycle, 1 time unit after the falling edge.
  task automatic run_queue();
    while (sb.size() > 0) begin
      #1;
      check_front();
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_instret = 32'd0;
    rst = 1'b0;
    bus.op = 7'b0010011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;

    push(mk(0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,3'b000,0), "reset_hold0");
    push(mk(0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,3'b000,0), "reset_hold1");
    run_queue();
    rst = 1'b1;

    issue(7'b0000011, 3'b010, 1'b0, 1'b0, "lw");          run_queue();
    issue(7'b0110011, 3'b000, 1'b1, 1'b0, "r_sub");       run_queue();
    issue(7'b0110011, 3'b111, 1'b0, 1'b0, "r_and");       run_queue();
    issue(7'b0110011, 3'b110, 1'b0, 1'b0, "r_or");        run_queue();
    issue(7'b0010011, 3'b000, 1'b1, 1'b0, "i_add_f7");    run_queue();
    issue(7'b0010011, 3'b010, 1'b0, 1'b0, "i_slt");       run_queue();
    issue(7'b0010011, 3'b100, 1'b0, 1'b0, "i_other");     run_queue();
    issue(7'b1101111, 3'b000, 1'b0, 1'b0, "jal");         run_queue();
    issue(7'b1100011, 3'b000, 1'b0, 1'b1, "beq_taken");   run_queue();
    issue(7'b1100011, 3'b000, 1'b0, 1'b0, "beq_not");     run_queue();
    issue(7'b0100011, 3'b010, 1'b0, 1'b0, "sw");          run_queue();
    issue(7'b1111111, 3'b000, 1'b0, 1'b0, "illegal");     run_queue();
    issue(7'b0010011, 3'b000, 1'b0, 1'b0, "after_ill");   run_queue();

    // Abort a load in MEMREAD with an asynchronous reset.
    issue(7'b0000011, 3'b010, 1'b0, 1'b0, "lw_abort");
    repeat (3) begin
      #1;
      check_front();
      @(negedge clk);
    end
    #1;
    check_front();
    sb.delete();
    rst = 1'b0;
    exp_instret = 32'd0;
    #1;
    push(mk(0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,3'b000,0), "abort_reset");
    check_front();
    @(negedge clk);
    rst = 1'b1;

    issue(7'b0100011, 3'b010, 1'b0, 1'b0, "sw_after_rst"); run_queue();
    issue(7'b0000011, 3'b010, 1'b0, 1'b0, "lw_final");     run_queue();

    tests++;
    assert (instret === exp_instret) else begin
      fails++;
      $error("FAIL final_instret observed=%0d expected=%0d", instret, exp_instret);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
